// File: rtl/cdb_broadcast_unit_pkg.sv
// Shared types and constants for the CDB broadcast unit.
// Source encoding, holding-entry record and small helpers used by the
// top level and its holding registers.
package cdb_pkg;

    localparam int CDB_DATA_W  = 32;
    localparam int CDB_TAG_W   = 6;
    localparam int CDB_NUM_SRC = 4;

    typedef enum logic [1:0] {
        SRC_INT  = 2'd0,
        SRC_MEM  = 2'd1,
        SRC_MULT = 2'd2,
        SRC_DIV  = 2'd3
    } cdb_src_e;

    typedef struct packed {
        logic                  valid;
        logic [CDB_TAG_W-1:0]  tag;
        logic [CDB_DATA_W-1:0] data;
    } cdb_entry_t;

    // Number of occupied holding registers.
    function automatic logic [2:0] occ_count(input logic [3:0] occ);
        logic [2:0] n;
        n = 3'd0;
        for (int i = 0; i < 4; i++) begin
            n = n + {2'b00, occ[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/cdb_broadcast_unit_if.sv
// Bus between the execution units and the CDB broadcast unit.
// master = execution-unit side (presents results, sees CDB);
// slave  = broadcast unit.
interface cdb_broadcast_unit_if #(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 6
);
    logic              i_int_valid;
    logic              i_mem_valid;
    logic              i_mult_valid;
    logic              i_div_valid;
    logic [TAG_W-1:0]  i_int_tag;
    logic [TAG_W-1:0]  i_mem_tag;
    logic [TAG_W-1:0]  i_mult_tag;
    logic [TAG_W-1:0]  i_div_tag;
    logic [DATA_W-1:0] i_int_data;
    logic [DATA_W-1:0] i_mem_data;
    logic [DATA_W-1:0] i_mult_data;
    logic [DATA_W-1:0] i_div_data;
    logic              o_int_ready;
    logic              o_mem_ready;
    logic              o_mult_ready;
    logic              o_div_ready;
    logic              o_cdb_valid;
    logic [TAG_W-1:0]  o_cdb_tag;
    logic [DATA_W-1:0] o_cdb_data;
    logic [1:0]        o_cdb_src;
    logic              o_collision;
    logic [7:0]        o_collision_cnt;

    modport master (
        output i_int_valid, i_mem_valid, i_mult_valid, i_div_valid,
        output i_int_tag, i_mem_tag, i_mult_tag, i_div_tag,
        output i_int_data, i_mem_data, i_mult_data, i_div_data,
        input  o_int_ready, o_mem_ready, o_mult_ready, o_div_ready,
        input  o_cdb_valid, o_cdb_tag, o_cdb_data, o_cdb_src,
        input  o_collision, o_collision_cnt
    );

    modport slave (
        input  i_int_valid, i_mem_valid, i_mult_valid, i_div_valid,
        input  i_int_tag, i_mem_tag, i_mult_tag, i_div_tag,
        input  i_int_data, i_mem_data, i_mult_data, i_div_data,
        output o_int_ready, o_mem_ready, o_mult_ready, o_div_ready,
        output o_cdb_valid, o_cdb_tag, o_cdb_data, o_cdb_src,
        output o_collision, o_collision_cnt
    );
endinterface

// File: rtl/cdb_broadcast_unit_hold_reg.sv
// One-entry holding register for a single execution unit.
// Accepts a result when empty or when its current entry is being granted
// onto the CDB this cycle, so a unit can stream one result per cycle.
module cdb_hold_reg #(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 6
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_flush,
    input  logic              i_valid,
    input  logic [TAG_W-1:0]  i_tag,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_grant,
    output logic              o_ready,
    output logic              o_valid,
    output logic [TAG_W-1:0]  o_tag,
    output logic [DATA_W-1:0] o_data
);

    logic              valid_r;
    logic [TAG_W-1:0]  tag_r;
    logic [DATA_W-1:0] data_r;
    logic              ready_s;

    // Ready when empty or when the held entry leaves this cycle.
    always_comb begin
        ready_s = ~valid_r | i_grant;
    end

    // Entry state: reset/flush empty it, a transfer loads it, a grant drains it.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            valid_r <= 1'b0;
            tag_r   <= '0;
            data_r  <= '0;
        end else if (i_flush) begin
            valid_r <= 1'b0;
        end else if (i_valid && ready_s) begin
            valid_r <= 1'b1;
            tag_r   <= i_tag;
            data_r  <= i_data;
        end else if (i_grant) begin
            valid_r <= 1'b0;
        end else begin
            valid_r <= valid_r;
        end
    end

    assign o_ready = ready_s;
    assign o_valid = valid_r;
    assign o_tag   = tag_r;
    assign o_data  = data_r;

endmodule

// File: rtl/cdb_broadcast_unit.sv
// CDB broadcast unit: captures results from the int, mem, mult and div
// units into per-source holding registers, picks one per cycle
// (div > mult > int/mem with an LRU bit between int and mem) and drives a
// registered CDB broadcast.
// Optional build macro CDB_COLLISION_CHECK_EN adds a sticky flag and a
// saturating counter of cycles where two or more holds were occupied.
module cdb_broadcast_unit
    import cdb_pkg::*;
#(
    parameter int DATA_W = CDB_DATA_W,
    parameter int TAG_W  = CDB_TAG_W
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_flush,
    cdb_broadcast_unit_if.slave  bus
);

    logic [3:0]        in_valid_s;
    logic [TAG_W-1:0]  in_tag_s   [4];
    logic [DATA_W-1:0] in_data_s  [4];
    logic [3:0]        hold_valid_s;
    logic [TAG_W-1:0]  hold_tag_s [4];
    logic [DATA_W-1:0] hold_data_s[4];
    logic [3:0]        ready_s;
    logic [3:0]        grant_s;
    logic              grant_any_s;
    cdb_src_e          grant_src_s;
    logic              lru_flip_s;
    logic [TAG_W-1:0]  sel_tag_s;
    logic [DATA_W-1:0] sel_data_s;

    logic              lru_r;
    logic              cdb_valid_r;
    logic [TAG_W-1:0]  cdb_tag_r;
    logic [DATA_W-1:0] cdb_data_r;
    logic [1:0]        cdb_src_r;

    // Gather the per-unit bus signals into arrays indexed by source code.
    always_comb begin
        in_valid_s   = {bus.i_div_valid, bus.i_mult_valid, bus.i_mem_valid, bus.i_int_valid};
        in_tag_s[0]  = bus.i_int_tag;
        in_tag_s[1]  = bus.i_mem_tag;
        in_tag_s[2]  = bus.i_mult_tag;
        in_tag_s[3]  = bus.i_div_tag;
        in_data_s[0] = bus.i_int_data;
        in_data_s[1] = bus.i_mem_data;
        in_data_s[2] = bus.i_mult_data;
        in_data_s[3] = bus.i_div_data;
    end

    for (genvar g = 0; g < 4; g++) begin : g_hold
        cdb_hold_reg #(
            .DATA_W (DATA_W),
            .TAG_W  (TAG_W)
        ) u_hold (
            .i_clk   (i_clk),
            .i_rst   (i_rst),
            .i_flush (i_flush),
            .i_valid (in_valid_s[g]),
            .i_tag   (in_tag_s[g]),
            .i_data  (in_data_s[g]),
            .i_grant (grant_s[g]),
            .o_ready (ready_s[g]),
            .o_valid (hold_valid_s[g]),
            .o_tag   (hold_tag_s[g]),
            .o_data  (hold_data_s[g])
        );
    end

    // Fixed-priority arbiter with an LRU tie-break between int and mem.
    always_comb begin
        grant_s     = 4'b0000;
        grant_any_s = 1'b0;
        grant_src_s = SRC_INT;
        lru_flip_s  = 1'b0;
        if (hold_valid_s[3]) begin
            grant_s[3]  = 1'b1;
            grant_any_s = 1'b1;
            grant_src_s = SRC_DIV;
        end else if (hold_valid_s[2]) begin
            grant_s[2]  = 1'b1;
            grant_any_s = 1'b1;
            grant_src_s = SRC_MULT;
        end else if (hold_valid_s[0] && hold_valid_s[1]) begin
            grant_any_s = 1'b1;
            lru_flip_s  = 1'b1;
            if (lru_r) begin
                grant_s[0]  = 1'b1;
                grant_src_s = SRC_INT;
            end else begin
                grant_s[1]  = 1'b1;
                grant_src_s = SRC_MEM;
            end
        end else if (hold_valid_s[0]) begin
            grant_s[0]  = 1'b1;
            grant_any_s = 1'b1;
            grant_src_s = SRC_INT;
        end else if (hold_valid_s[1]) begin
            grant_s[1]  = 1'b1;
            grant_any_s = 1'b1;
            grant_src_s = SRC_MEM;
        end else begin
            grant_any_s = 1'b0;
        end
    end

    // Select the granted entry's tag and data.
    always_comb begin
        case (grant_src_s)
            SRC_INT: begin
                sel_tag_s  = hold_tag_s[0];
                sel_data_s = hold_data_s[0];
            end
            SRC_MEM: begin
                sel_tag_s  = hold_tag_s[1];
                sel_data_s = hold_data_s[1];
            end
            SRC_MULT: begin
                sel_tag_s  = hold_tag_s[2];
                sel_data_s = hold_data_s[2];
            end
            SRC_DIV: begin
                sel_tag_s  = hold_tag_s[3];
                sel_data_s = hold_data_s[3];
            end
            default: begin
                sel_tag_s  = hold_tag_s[0];
                sel_data_s = hold_data_s[0];
            end
        endcase
    end

    // CDB output register and int/mem LRU bit; flush leaves the LRU bit alone.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cdb_valid_r <= 1'b0;
            cdb_tag_r   <= '0;
            cdb_data_r  <= '0;
            cdb_src_r   <= 2'd0;
            lru_r       <= 1'b1;
        end else if (i_flush) begin
            cdb_valid_r <= 1'b0;
        end else if (grant_any_s) begin
            cdb_valid_r <= 1'b1;
            cdb_tag_r   <= sel_tag_s;
            cdb_data_r  <= sel_data_s;
            cdb_src_r   <= grant_src_s;
            if (lru_flip_s) begin
                lru_r <= ~lru_r;
            end else begin
                lru_r <= lru_r;
            end
        end else begin
            cdb_valid_r <= 1'b0;
        end
    end

`ifdef CDB_COLLISION_CHECK_EN
    logic       coll_r;
    logic [7:0] coll_cnt_r;
    logic       multi_s;

    // Two or more occupied holds means the upstream slot reservation slipped.
    always_comb begin
        multi_s = (occ_count(hold_valid_s) >= 3'd2);
    end

    // Sticky collision flag and saturating collision counter.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            coll_r     <= 1'b0;
            coll_cnt_r <= 8'd0;
        end else if (i_flush) begin
            coll_r     <= coll_r;
        end else if (multi_s) begin
            coll_r <= 1'b1;
            if (coll_cnt_r != 8'hFF) begin
                coll_cnt_r <= coll_cnt_r + 8'd1;
            end else begin
                coll_cnt_r <= coll_cnt_r;
            end
        end else begin
            coll_r <= coll_r;
        end
    end

    assign bus.o_collision     = coll_r;
    assign bus.o_collision_cnt = coll_cnt_r;
`else
    assign bus.o_collision     = 1'b0;
    assign bus.o_collision_cnt = 8'd0;
`endif

    assign bus.o_int_ready  = ready_s[0];
    assign bus.o_mem_ready  = ready_s[1];
    assign bus.o_mult_ready = ready_s[2];
    assign bus.o_div_ready  = ready_s[3];
    assign bus.o_cdb_valid  = cdb_valid_r;
    assign bus.o_cdb_tag    = cdb_tag_r;
    assign bus.o_cdb_data   = cdb_data_r;
    assign bus.o_cdb_src    = cdb_src_r;

endmodule

// File: tb/tb_cdb_broadcast_unit.sv
// Bench for cdb_broadcast_unit: a directed vector table, hand-written
// backpressure/flush/collision sequences and a randomized phase checked
// against a behavioural model of the slot/priority rules.
module tb_cdb_broadcast_unit;
    import cdb_pkg::*;

    logic i_clk = 1'b0;
    logic i_rst = 1'b0;
    logic i_flush = 1'b0;

    cdb_broadcast_unit_if #(.DATA_W(32), .TAG_W(6)) bus ();

    cdb_broadcast_unit #(.DATA_W(32), .TAG_W(6)) dut (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_flush (i_flush),
        .bus     (bus)
    );

    always #5 i_clk = ~i_clk;

    int checks = 0;
    int failures = 0;

    // stimulus presented by the four units (0 int, 1 mem, 2 mult, 3 div)
    logic [3:0]  in_v = 4'b0000;
    logic [5:0]  in_tag [4];
    logic [31:0] in_data[4];
    logic [3:0]  last_acc = 4'b0000;

    // behavioural model state
    logic        m_known = 1'b0;
    logic [3:0]  m_occ = 4'b0000;
    logic [5:0]  m_tag [4];
    logic [31:0] m_data[4];
    logic        m_lru = 1'b1;
    logic        m_cv = 1'b0;
    logic [5:0]  m_ct = 6'd0;
    logic [31:0] m_cd = 32'd0;
    logic [1:0]  m_cs = 2'd0;
    logic        m_coll = 1'b0;
    int          m_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Which source the CDB should carry next, from the priority rules.
    function automatic int model_winner();
        if (m_occ[3]) return 3;
        if (m_occ[2]) return 2;
        if (m_occ[0] && m_occ[1]) return m_lru ? 0 : 1;
        if (m_occ[0]) return 0;
        if (m_occ[1]) return 1;
        return -1;
    endfunction

    task automatic model_edge(input logic rst, input logic flush, input logic [3:0] rdy);
        int w;
        if (rst) begin
            m_known = 1'b1;
            m_occ = 4'b0000;
            m_lru = 1'b1;
            m_cv = 1'b0; m_ct = 6'd0; m_cd = 32'd0; m_cs = 2'd0;
            m_coll = 1'b0; m_cnt = 0;
        end else if (flush) begin
            m_occ = 4'b0000;
            m_cv = 1'b0;
        end else begin
            w = model_winner();
`ifdef CDB_COLLISION_CHECK_EN
            if ($countones(m_occ) >= 2) begin
                m_coll = 1'b1;
                if (m_cnt < 255) m_cnt++;
            end
`endif
            if (w >= 0) begin
                m_cv = 1'b1;
                m_ct = m_tag[w];
                m_cd = m_data[w];
                m_cs = 2'(w);
                if (m_occ[0] && m_occ[1] && w < 2) m_lru = (w == 1);
                m_occ[w] = 1'b0;
            end else begin
                m_cv = 1'b0;
            end
            for (int i = 0; i < 4; i++) begin
                if (in_v[i] && rdy[i]) begin
                    m_occ[i] = 1'b1;
                    m_tag[i] = in_tag[i];
                    m_data[i] = in_data[i];
                end
            end
        end
    endtask

    function automatic logic [3:0] dut_rdy();
        return {bus.o_div_ready, bus.o_mult_ready, bus.o_mem_ready, bus.o_int_ready};
    endfunction

    // One clock: drive inputs, check readies, advance, check the CDB.
    task automatic cycle(input logic rst, input logic flush);
        logic [3:0] exp_rdy;
        int w;
        i_rst = rst;
        i_flush = flush;
        bus.i_int_valid = in_v[0];  bus.i_int_tag = in_tag[0];  bus.i_int_data = in_data[0];
        bus.i_mem_valid = in_v[1];  bus.i_mem_tag = in_tag[1];  bus.i_mem_data = in_data[1];
        bus.i_mult_valid = in_v[2]; bus.i_mult_tag = in_tag[2]; bus.i_mult_data = in_data[2];
        bus.i_div_valid = in_v[3];  bus.i_div_tag = in_tag[3];  bus.i_div_data = in_data[3];
        #1;
        w = model_winner();
        for (int i = 0; i < 4; i++) exp_rdy[i] = !m_occ[i] || (w == i);
        if (m_known) chk("ready", 32'(dut_rdy()), 32'(exp_rdy));
        last_acc = (rst || flush) ? 4'b0000 : (in_v & exp_rdy);
        @(posedge i_clk);
        #1;
        model_edge(rst, flush, exp_rdy);
        if (m_known) begin
            chk("cdb_valid", 32'(bus.o_cdb_valid), 32'(m_cv));
            chk("cdb_tag", 32'(bus.o_cdb_tag), 32'(m_ct));
            chk("cdb_data", bus.o_cdb_data, m_cd);
            chk("cdb_src", 32'(bus.o_cdb_src), 32'(m_cs));
            chk("collision", 32'(bus.o_collision), 32'(m_coll));
            chk("collision_cnt", 32'(bus.o_collision_cnt), 32'(m_cnt));
        end
    endtask

    task automatic set_in(input logic [3:0] v, input logic [23:0] tags);
        logic [5:0] t;
        in_v = v;
        for (int i = 0; i < 4; i++) begin
            t = tags[i*6 +: 6];
            in_tag[i] = t;
            in_data[i] = 32'hDEADBEEA + {26'd0, t};
        end
    endtask

    typedef struct {
        logic        rst;
        logic [3:0]  vld;   // {div, mult, mem, int}
        logic [23:0] tags;  // {div, mult, mem, int}
        logic        ev;
        logic [5:0]  etag;
        logic [1:0]  esrc;
        logic [3:0]  erdy;  // readies after the edge
    } vec_t;

    vec_t tbl[13];

    function automatic vec_t mk(logic rst, logic [3:0] vld, logic [23:0] tags,
                                logic ev, logic [5:0] etag, logic [1:0] esrc, logic [3:0] erdy);
        vec_t v;
        v.rst = rst; v.vld = vld; v.tags = tags; v.ev = ev;
        v.etag = etag; v.esrc = esrc; v.erdy = erdy;
        return v;
    endfunction

    initial begin
        for (int i = 0; i < 4; i++) begin
            in_tag[i] = 6'd0; in_data[i] = 32'd0;
            m_tag[i] = 6'd0; m_data[i] = 32'd0;
        end

        tbl[0]  = mk(1'b1, 4'b1111, {6'd3, 6'd4, 6'd2, 6'd1}, 1'b0, 6'd0, 2'd0, 4'b1111);
        tbl[1]  = mk(1'b1, 4'b1111, {6'd3, 6'd4, 6'd2, 6'd1}, 1'b0, 6'd0, 2'd0, 4'b1111);
        tbl[2]  = mk(1'b0, 4'b0001, {6'd0, 6'd0, 6'd0, 6'd5}, 1'b0, 6'd0, 2'd0, 4'b1111);
        tbl[3]  = mk(1'b0, 4'b0000, 24'd0, 1'b1, 6'd5, 2'd0, 4'b1111);
        tbl[4]  = mk(1'b0, 4'b0000, 24'd0, 1'b0, 6'd5, 2'd0, 4'b1111);
        tbl[5]  = mk(1'b0, 4'b1011, {6'd3, 6'd0, 6'd2, 6'd1}, 1'b0, 6'd5, 2'd0, 4'b1100);
        tbl[6]  = mk(1'b0, 4'b0000, 24'd0, 1'b1, 6'd3, 2'd3, 4'b1101);
        tbl[7]  = mk(1'b0, 4'b0000, 24'd0, 1'b1, 6'd1, 2'd0, 4'b1111);
        tbl[8]  = mk(1'b0, 4'b0000, 24'd0, 1'b1, 6'd2, 2'd1, 4'b1111);
        tbl[9]  = mk(1'b0, 4'b0011, {6'd0, 6'd0, 6'd2, 6'd1}, 1'b0, 6'd2, 2'd1, 4'b1110);
        tbl[10] = mk(1'b0, 4'b0000, 24'd0, 1'b1, 6'd2, 2'd1, 4'b1111);
        tbl[11] = mk(1'b0, 4'b0000, 24'd0, 1'b1, 6'd1, 2'd0, 4'b1111);
        tbl[12] = mk(1'b0, 4'b0000, 24'd0, 1'b0, 6'd1, 2'd0, 4'b1111);

        // directed vector table: reset, single int, div/int/mem order, LRU
        for (int r = 0; r < 13; r++) begin
            set_in(tbl[r].vld, tbl[r].tags);
            cycle(tbl[r].rst, 1'b0);
            chk($sformatf("tbl%0d_valid", r), 32'(bus.o_cdb_valid), 32'(tbl[r].ev));
            chk($sformatf("tbl%0d_tag", r), 32'(bus.o_cdb_tag), 32'(tbl[r].etag));
            chk($sformatf("tbl%0d_src", r), 32'(bus.o_cdb_src), 32'(tbl[r].esrc));
            chk($sformatf("tbl%0d_rdy", r), 32'(dut_rdy()), 32'(tbl[r].erdy));
            if (tbl[r].ev)
                chk($sformatf("tbl%0d_data", r), bus.o_cdb_data, 32'hDEADBEEA + 32'(tbl[r].etag));
        end

        // backpressure: div streams 10..13 while mult sits in its hold
        set_in(4'b1100, {6'd10, 6'd20, 6'd0, 6'd0});
        cycle(1'b0, 1'b0);
        chk("bp_mult_rdy0", 32'(bus.o_mult_ready), 32'd0);
        for (int k = 1; k <= 3; k++) begin
            set_in(4'b1100, {6'(10 + k), 6'd21, 6'd0, 6'd0});
            cycle(1'b0, 1'b0);
            chk($sformatf("bp_div_tag%0d", k), 32'(bus.o_cdb_tag), 32'(9 + k));
            chk($sformatf("bp_div_v%0d", k), 32'(bus.o_cdb_valid & (bus.o_cdb_src == 2'd3)), 32'd1);
            chk($sformatf("bp_mult_rdy%0d", k), 32'(bus.o_mult_ready), 32'd0);
        end
        set_in(4'b0100, {6'd0, 6'd21, 6'd0, 6'd0});
        cycle(1'b0, 1'b0);
        chk("bp_div_last", 32'(bus.o_cdb_tag), 32'd13);
        chk("bp_mult_rdy_free", 32'(bus.o_mult_ready), 32'd1);
        cycle(1'b0, 1'b0);
        chk("bp_mult_first", 32'({bus.o_cdb_valid, bus.o_cdb_src, bus.o_cdb_tag}), 32'({1'b1, 2'd2, 6'd20}));
        set_in(4'b0000, 24'd0);
        cycle(1'b0, 1'b0);
        chk("bp_mult_second", 32'({bus.o_cdb_valid, bus.o_cdb_src, bus.o_cdb_tag}), 32'({1'b1, 2'd2, 6'd21}));
        cycle(1'b0, 1'b0);

        // flush drops held int(7) and mult(8)
        set_in(4'b0101, {6'd0, 6'd8, 6'd0, 6'd7});
        cycle(1'b0, 1'b0);
        set_in(4'b0000, 24'd0);
        cycle(1'b0, 1'b1);
        chk("flush_valid", 32'(bus.o_cdb_valid), 32'd0);
        chk("flush_rdy", 32'(dut_rdy()), 32'hF);
        for (int k = 0; k < 2; k++) begin
            cycle(1'b0, 1'b0);
            chk($sformatf("flush_quiet%0d", k), 32'(bus.o_cdb_valid), 32'd0);
        end

        // collision: three results land together after a reset
        cycle(1'b1, 1'b0);
        set_in(4'b1011, {6'd3, 6'd0, 6'd2, 6'd1});
        cycle(1'b0, 1'b0);
        set_in(4'b0000, 24'd0);
        for (int k = 0; k < 3; k++) cycle(1'b0, 1'b0);
`ifdef CDB_COLLISION_CHECK_EN
        chk("coll_flag", 32'(bus.o_collision), 32'd1);
        chk("coll_cnt", 32'(bus.o_collision_cnt), 32'd2);
`else
        chk("coll_flag", 32'(bus.o_collision), 32'd0);
        chk("coll_cnt", 32'(bus.o_collision_cnt), 32'd0);
`endif

        // randomized traffic with occasional flush and reset
        for (int n = 0; n < 500; n++) begin
            logic r, f;
            for (int i = 0; i < 4; i++) begin
                if (!in_v[i] || last_acc[i]) begin
                    in_v[i] = ($urandom_range(0, 99) < 55);
                    in_tag[i] = 6'($urandom);
                    in_data[i] = $urandom;
                end
            end
            r = ($urandom_range(0, 99) < 2);
            f = ($urandom_range(0, 99) < 4);
            cycle(r, f);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
